// File: rtl/edge_pipeline_param.sv
// Streaming Sobel edge pipeline: ZBT unpack, grayscale, two line buffers, 3x3 window,
// saturated magnitude with border suppression and four frame-registered display modes.
module edge_pipeline_param #(
    parameter int unsigned COLS     = 1344,
    parameter int unsigned HCOUNT_W = 11,
    parameter int unsigned GRAY_W   = 8,
    parameter int unsigned LATENCY  = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic                sof,
    input  logic [23:0]         rgb_lo,
    input  logic [23:0]         rgb_hi,
    input  logic [HCOUNT_W-1:0] hcount,
    input  logic [1:0]          mode,
    input  logic [GRAY_W-1:0]   threshold,
    input  logic [23:0]         edge_color,
    output logic [23:0]         pix_out,
    output logic                out_valid,
    output logic                select,
    output logic [GRAY_W-1:0]   edge_mag
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned SW    = GRAY_W + 3;
    localparam logic [GRAY_W-1:0] MAG_MAX = '1;

    logic [23:0]         rgb_sel;
    logic [15:0]         y_sum;
    logic [COL_W-1:0]    col_q, col_cur;
    logic [HCOUNT_W-1:0] row_q, row_cur;
    logic                start, border_in;
    logic                unused_hcount;
    logic [1:0]          mode_q;
    logic [GRAY_W-1:0]   thr_q;
    logic [23:0]         color_q;

    assign unused_hcount = ^hcount[HCOUNT_W-1:1];
    assign start     = sof & pix_valid;
    assign rgb_sel   = hcount[0] ? rgb_lo : rgb_hi;
    assign y_sum     = 16'd77 * {8'd0, rgb_sel[23:16]} + 16'd150 * {8'd0, rgb_sel[15:8]}
                     + 16'd29 * {8'd0, rgb_sel[7:0]};
    assign col_cur   = sof ? '0 : col_q;
    assign row_cur   = sof ? '0 : row_q;
    assign border_in = (row_cur < HCOUNT_W'(2)) || (col_cur < COL_W'(2));

    // col/row hold the position the next accepted pixel will occupy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_valid) begin
            if (col_cur == COL_W'(COLS - 1)) begin
                col_q <= '0;
                row_q <= (row_cur == '1) ? row_cur : row_cur + 1'b1;
            end else begin
                col_q <= col_cur + 1'b1;
                row_q <= row_cur;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q  <= '0;
            thr_q   <= '0;
            color_q <= '0;
        end else if (start) begin
            mode_q  <= mode;
            thr_q   <= threshold;
            color_q <= edge_color;
        end
    end

    // Stage 1: grayscale
    logic [LATENCY-1:0] vld_q;
    logic [GRAY_W-1:0]  y1_q;
    logic               b1_q, b2_q, b3_q, b4_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            y1_q  <= '0;
            b1_q  <= 1'b0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], pix_valid};
            if (pix_valid) begin
                y1_q <= y_sum[15 -: GRAY_W];
                b1_q <= border_in;
            end
        end
    end

    logic [GRAY_W-1:0] line0 [COLS];
    logic [GRAY_W-1:0] line1 [COLS];

    always_ff @(posedge clock) begin
        if (vld_q[0]) begin
            line0[0] <= y1_q;
            line1[0] <= line0[COLS-1];
            for (int i = 1; i < COLS; i++) begin
                line0[i] <= line0[i-1];
                line1[i] <= line1[i-1];
            end
        end
    end

    // Stage 2: window, row 0 = oldest line, column 2 = newest pixel
    logic [GRAY_W-1:0] win_q [3][3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            b2_q <= 1'b0;
        end else if (vld_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[2][2] <= y1_q;
            win_q[1][2] <= line0[COLS-1];
            win_q[0][2] <= line1[COLS-1];
            b2_q        <= b1_q;
        end
    end

    // Stage 3: gradients
    function automatic logic signed [SW-1:0] sx(input logic [GRAY_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic signed [SW-1:0] gx, gy, ax, ay;
    logic [SW-2:0]        ax3_q, ay3_q;
    logic [GRAY_W-1:0]    yc3_q;

    always_comb begin
        gx = (sx(win_q[0][2]) + sx(win_q[1][2]) + sx(win_q[1][2]) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + sx(win_q[1][0]) + sx(win_q[1][0]) + sx(win_q[2][0]));
        gy = (sx(win_q[2][0]) + sx(win_q[2][1]) + sx(win_q[2][1]) + sx(win_q[2][2]))
           - (sx(win_q[0][0]) + sx(win_q[0][1]) + sx(win_q[0][1]) + sx(win_q[0][2]));
        ax = gx[SW-1] ? -gx : gx;
        ay = gy[SW-1] ? -gy : gy;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ax3_q <= '0;
            ay3_q <= '0;
            yc3_q <= '0;
            b3_q  <= 1'b0;
        end else if (vld_q[1]) begin
            ax3_q <= ax[SW-2:0];
            ay3_q <= ay[SW-2:0];
            yc3_q <= win_q[1][1];
            b3_q  <= b2_q;
        end
    end

    // Stage 4: saturated magnitude
    logic [SW-1:0]     mag_sum;
    logic [GRAY_W-1:0] mag_d, mag4_q, yc4_q;

    always_comb begin
        mag_sum = {1'b0, ax3_q} + {1'b0, ay3_q};
        mag_d   = (mag_sum > {3'b000, MAG_MAX}) ? MAG_MAX : mag_sum[GRAY_W-1:0];
        if (b3_q) begin
            mag_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag4_q <= '0;
            yc4_q  <= '0;
            b4_q   <= 1'b0;
        end else if (vld_q[2]) begin
            mag4_q <= mag_d;
            yc4_q  <= yc3_q;
            b4_q   <= b3_q;
        end
    end

    // Stage 5: threshold and display mode
    logic [7:0]  yc8, mag8;
    logic        edge_hit;
    logic [23:0] pix_d;

    assign yc8  = yc4_q[GRAY_W-1 -: 8];
    assign mag8 = mag4_q[GRAY_W-1 -: 8];

    always_comb begin
        edge_hit = ~b4_q & (mag4_q > thr_q);
        pix_d    = '0;
        case (mode_q)
            2'd0:    pix_d = {yc8, yc8, yc8};
            2'd1:    pix_d = ~{mag8, mag8, mag8};
            2'd2:    pix_d = edge_hit ? 24'hFFFFFF : 24'h000000;
            default: pix_d = edge_hit ? color_q : {yc8, yc8, yc8};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_out  <= '0;
            select   <= 1'b0;
            edge_mag <= '0;
        end else if (vld_q[3]) begin
            pix_out  <= pix_d;
            select   <= edge_hit;
            edge_mag <= mag4_q;
        end
    end

    assign out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_edge_pipeline_param.sv
// Scoreboard bench for edge_pipeline_param: a stream-history Sobel model predicts every output
// pixel; a negedge monitor pops and compares, and per-test tasks check frame-level results.
module tb_edge_pipeline_param;
    localparam int unsigned COLS     = 8;
    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned GRAY_W   = 8;
    localparam int C    = 8;
    localparam int ROWS = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                pix_valid = 1'b0;
    logic                sof = 1'b0;
    logic [23:0]         rgb_lo = '0;
    logic [23:0]         rgb_hi = '0;
    logic [HCOUNT_W-1:0] hcount = '0;
    logic [1:0]          mode = '0;
    logic [GRAY_W-1:0]   threshold = '0;
    logic [23:0]         edge_color = '0;
    logic [23:0]         pix_out;
    logic                out_valid;
    logic                select;
    logic [GRAY_W-1:0]   edge_mag;

    always #5 clock = ~clock;

    edge_pipeline_param #(
        .COLS    (COLS),
        .HCOUNT_W(HCOUNT_W),
        .GRAY_W  (GRAY_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pix_valid (pix_valid),
        .sof       (sof),
        .rgb_lo    (rgb_lo),
        .rgb_hi    (rgb_hi),
        .hcount    (hcount),
        .mode      (mode),
        .threshold (threshold),
        .edge_color(edge_color),
        .pix_out   (pix_out),
        .out_valid (out_valid),
        .select    (select),
        .edge_mag  (edge_mag)
    );

    typedef struct {
        logic [23:0] pix;
        logic        sel;
        logic [7:0]  mag;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_e;
    bit          have_last = 1'b0;
    bit          mon_en = 1'b0;
    int          hist[$];
    int          m_col = 0;
    int          m_row = 0;
    logic [1:0]  sh_mode = '0;
    logic [7:0]  sh_thr = '0;
    logic [23:0] sh_color = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          sel_count = 0;

    function automatic int gray_of(input logic [23:0] rgb);
        return (77 * int'(rgb[23:16]) + 150 * int'(rgb[15:8]) + 29 * int'(rgb[7:0])) >> 8;
    endfunction

    // Gray of the i-th accepted pixel; anything before the model's history reads as 0
    function automatic int h(input int i);
        if (i < 0) return 0;
        return hist[i];
    endfunction

    function automatic void model_push(input int row, input int col);
        int   n, gx, gy, mag, yc;
        bit   border, hit;
        exp_t e;
        n  = hist.size() - 1;
        gx = (h(n) + 2 * h(n - C) + h(n - 2 * C)) - (h(n - 2) + 2 * h(n - C - 2) + h(n - 2 * C - 2));
        gy = (h(n) + 2 * h(n - 1) + h(n - 2))
           - (h(n - 2 * C) + 2 * h(n - 2 * C - 1) + h(n - 2 * C - 2));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (mag > 255) mag = 255;
        border = (row < 2) || (col < 2);
        if (border) mag = 0;
        hit   = !border && (mag > int'(sh_thr));
        yc    = h(n - C - 1);
        e.mag = 8'(mag);
        e.sel = hit;
        case (sh_mode)
            2'd0:    e.pix = {8'(yc), 8'(yc), 8'(yc)};
            2'd1:    e.pix = ~{8'(mag), 8'(mag), 8'(mag)};
            2'd2:    e.pix = hit ? 24'hFFFFFF : 24'h000000;
            default: e.pix = hit ? sh_color : {8'(yc), 8'(yc), 8'(yc)};
        endcase
        exp_q.push_back(e);
    endfunction

    task automatic send_pixel(input logic [23:0] rgb, input bit first, input bit use_lo);
        @(negedge clock);
        pix_valid = 1'b1;
        sof       = first;
        hcount    = HCOUNT_W'($urandom);
        hcount[0] = use_lo;
        if (use_lo) begin
            rgb_lo = rgb;
            rgb_hi = 24'($urandom);
        end else begin
            rgb_hi = rgb;
            rgb_lo = 24'($urandom);
        end
        if (first) begin
            m_col    = 0;
            m_row    = 0;
            sh_mode  = mode;
            sh_thr   = threshold;
            sh_color = edge_color;
        end
        hist.push_back(gray_of(rgb));
        model_push(m_row, m_col);
        if (m_col == C - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            pix_valid = 1'b0;
            sof       = 1'b0;
        end
    endtask

    function automatic logic [23:0] frame_rgb(input int kind, input int col);
        case (kind)
            0:       return 24'h808080;
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            default: return (col < 4) ? 24'h000000 : 24'hFFFFFF;
        endcase
    endfunction

    // change_at: pixel index where mode/threshold/colour inputs are altered mid-frame
    task automatic send_frame(input int kind, input bit bubbles, input int change_at);
        bit use_lo;
        for (int i = 0; i < ROWS * C; i++) begin
            if (i == change_at) begin
                mode       = 2'd3;
                edge_color = 24'h00FF00;
                threshold  = 8'hFF;
            end
            use_lo = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : bit'(i % 2);
            send_pixel(frame_rgb(kind, i % C), i == 0, use_lo);
            if (bubbles) idle(1);
        end
        idle(8);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (out_valid) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output pix_out=%h select=%b edge_mag=%h, none expected",
                             pix_out, select, edge_mag);
                end else begin
                    last_e    = exp_q.pop_front();
                    have_last = 1'b1;
                    if (pix_out !== last_e.pix || select !== last_e.sel || edge_mag !== last_e.mag)
                        $display("FAIL scoreboard got pix_out=%h select=%b edge_mag=%h, want %h %b %h",
                                 pix_out, select, edge_mag, last_e.pix, last_e.sel, last_e.mag);
                    else
                        pass_cnt++;
                end
                if (select === 1'b1) sel_count++;
            end else if (have_last) begin
                total_cnt++;
                if (pix_out !== last_e.pix || select !== last_e.sel || edge_mag !== last_e.mag)
                    $display("FAIL hold got pix_out=%h select=%b edge_mag=%h, want %h %b %h",
                             pix_out, select, edge_mag, last_e.pix, last_e.sel, last_e.mag);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (pix_out !== 24'h0) $display("FAIL reset_pix_out got %h want 000000", pix_out);
        else pass_cnt++;
        total_cnt++;
        if (select !== 1'b0) $display("FAIL reset_select got %b want 0", select);
        else pass_cnt++;
        total_cnt++;
        if (edge_mag !== 8'h0) $display("FAIL reset_edge_mag got %h want 00", edge_mag);
        else pass_cnt++;
        reset = 1'b0;
        idle(2);
        mon_en = 1'b1;
    endtask

    task automatic test_flat;
        mode      = 2'd1;
        threshold = 8'h40;
        sel_count = 0;
        send_frame(0, 1'b0, -1);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL flat_drain got %0d pending want 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (pix_out !== 24'hFFFFFF) $display("FAIL flat_pix got %h want FFFFFF", pix_out);
        else pass_cnt++;
        total_cnt++;
        if (sel_count != 0) $display("FAIL flat_edges got %0d want 0", sel_count);
        else pass_cnt++;
    endtask

    task automatic test_gray;
        mode = 2'd0;
        send_frame(1, 1'b0, -1);
        total_cnt++;
        if (pix_out !== 24'h4C4C4C) $display("FAIL gray_red_lo got %h want 4C4C4C", pix_out);
        else pass_cnt++;
        send_frame(2, 1'b0, -1);
        total_cnt++;
        if (pix_out !== 24'h959595) $display("FAIL gray_green_hi got %h want 959595", pix_out);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL gray_drain got %0d pending want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_step(input bit bubbles);
        mode      = 2'd2;
        threshold = 8'h40;
        sel_count = 0;
        send_frame(3, bubbles, -1);
        total_cnt++;
        if (sel_count != 4) $display("FAIL step_edges bubbles=%0d got %0d want 4", bubbles, sel_count);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL step_drain got %0d pending want 0", exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (pix_out !== 24'h000000) $display("FAIL step_last_pix got %h want 000000", pix_out);
        else pass_cnt++;
    endtask

    task automatic test_mode_shadow;
        mode       = 2'd2;
        threshold  = 8'h40;
        edge_color = 24'hFF0000;
        sel_count  = 0;
        send_frame(3, 1'b0, 12);
        total_cnt++;
        if (sel_count != 4) $display("FAIL shadow_midframe_edges got %0d want 4", sel_count);
        else pass_cnt++;
        threshold = 8'h40;
        sel_count = 0;
        send_frame(3, 1'b0, -1);
        total_cnt++;
        if (sel_count != 4) $display("FAIL shadow_overlay_edges got %0d want 4", sel_count);
        else pass_cnt++;
        total_cnt++;
        if (pix_out !== 24'hFFFFFF) $display("FAIL shadow_overlay_last got %h want FFFFFF", pix_out);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL shadow_drain got %0d pending want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        mon_en = 1'b0;
        mode   = 2'd1;
        for (int i = 0; i < 12; i++) send_pixel(24'h808080, i == 0, 1'b1);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL midreset_pre_valid got %b want 1", out_valid);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, select} !== 2'b00) $display("FAIL midreset_flags got %b want 00",
                                                    {out_valid, select});
        else pass_cnt++;
        total_cnt++;
        if (pix_out !== 24'h0 || edge_mag !== 8'h0)
            $display("FAIL midreset_data got %h/%h want 000000/00", pix_out, edge_mag);
        else pass_cnt++;
        @(negedge clock);
        pix_valid = 1'b0;
        sof       = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL midreset_idle cycle %0d got %b want 0", i, out_valid);
            else pass_cnt++;
        end
        send_pixel(24'h808080, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            pix_valid = 1'b0;
            sof       = 1'b0;
            total_cnt++;
            if (out_valid !== (i == 5))
                $display("FAIL midreset_latency cycle %0d got %b want %b", i, out_valid, i == 5);
            else pass_cnt++;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_flat();
        test_gray();
        test_step(1'b0);
        test_step(1'b1);
        test_mode_shadow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
